// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampling, 3-sample majority voting,
// parity/framing/overrun detection and a one-entry valid/ready output register.
module uart_rx_param #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,  // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS  = 1   // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_V0     = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_V1     = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]   S_RES    = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [S_W-1:0]       s_cnt;
  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 par_flag;
  logic                 frame_flag;
  logic                 v0;
  logic                 v1;

  logic tick;
  logic at_v0;
  logic at_v1;
  logic at_res;
  logic at_wrap;
  logic vote;
  logic parity_exp;
  logic stop_final;
  logic frame_done;
  logic frame_flag_next;

  assign tick    = (div_cnt == DIV_LAST);
  assign at_v0   = tick && (s_cnt == S_V0);
  assign at_v1   = tick && (s_cnt == S_V1);
  assign at_res  = tick && (s_cnt == S_RES);
  assign at_wrap = tick && (s_cnt == S_LAST);

  // Majority of the two stored samples and the live third sample.
  assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  // Expected parity bit: even parity repeats the data XOR, odd inverts it.
  assign parity_exp = (PARITY == 1) ? ~(^shift) : (^shift);

  assign stop_final      = (stop_idx == STOP_LAST);
  assign frame_done      = (state == ST_STOP) && at_res && stop_final;
  assign frame_flag_next = frame_flag | ~vote;

  assign busy = (state != ST_IDLE);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes rx_meta -> rx_s a real two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Baud divider and sample counter; held at zero while idle so a start edge
  // always begins a fresh bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      s_cnt   <= (s_cnt == S_LAST) ? '0 : s_cnt + S_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Capture the first two vote samples of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (at_v0) v0 <= rx_s;
      if (at_v1) v1 <= rx_s;
    end
  end

  // Frame FSM: start qualification, data shift, parity and stop checking.
  // NOTE: the shift register is reset along with the control state; it is
  // small, and a defined value keeps parity and rx_data deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_flag   <= 1'b0;
      frame_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state      <= ST_START;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_flag   <= 1'b0;
            frame_flag <= 1'b0;
          end
        end
        ST_START: begin
          if (at_res && vote) state <= ST_IDLE;   // false start
          else if (at_wrap)   state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_res) begin
            shift   <= {vote, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_W'(1);
          end
          if (at_wrap && (bit_idx == BIT_LAST))
            state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (at_res)  par_flag <= (vote != parity_exp);
          if (at_wrap) state    <= ST_STOP;
        end
        ST_STOP: begin
          if (at_res) begin
            if (!vote) frame_flag <= 1'b1;
            // The frame completes at the final stop bit's resolution tick.
            if (stop_final)
              state <= (frame_flag_next && !rx_s) ? ST_BREAK : ST_IDLE;
          end
          if (at_wrap) stop_idx <= stop_idx + 1'b1;
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry output register: load on completion if empty or being drained,
  // otherwise drop the new frame and pulse overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift;
          parity_err <= par_flag;
          frame_err  <= frame_flag_next;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that replaces the fixed 8N1 receiver on the host-link path of the 10x10 pipeline. It supports configurable data width, parity and stop bits, and samples with 16x (configurable) oversampling and 3-sample majority voting. It flags parity, framing and overrun errors. Received words go to the pipeline loader through a one-entry valid/ready output register, so no byte is lost while the consumer is stalled for less than one frame time.

## Interface
- CLOCK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit; even, at least 8.
- DATA_BITS, 8: payload bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line; asynchronous; idles high.
- rx_data  out  DATA_BITS  received payload; valid while rx_valid=1.
- rx_valid  out  1  payload present in the output register.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready.
- parity_err  out  1  qualified by rx_valid; parity mismatch in the held word.
- frame_err  out  1  qualified by rx_valid; a stop bit sampled 0 in the held word.
- overrun_err  out  1  one-cycle pulse: a completed frame was discarded.
- busy  out  1  the FSM is not in IDLE.

## Operation
- Input sync: rx passes through a 2-flop synchroniser (rx_s), which resets to 1. All decisions use rx_s.
- Divider: DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, must be at least 1.
  - The divider counter counts 0..DIV-1 and emits a one-clock tick at DIV-1.
  - The divider counter and the sample counter s (0..OVERSAMPLE-1) are cleared when a start edge is detected.
- Majority vote: each bit value is the majority of rx_s at ticks with s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit is resolved at the tick with s = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rx_s = 0, go to START and clear the counters.
  - START: at bit resolution, a voted 1 is a false start; return to IDLE and emit nothing. A voted 0 continues; at s wrap, go to DATA.
  - DATA: shift in the voted bit, LSB first, into shift[DATA_BITS-1:0]. Bit index width is $clog2(DATA_BITS+1). After DATA_BITS bits, go to PARITY if PARITY≠0, else go to STOP.
  - PARITY: compare the voted bit with the XOR of the data bits, inverted for odd parity. A mismatch sets the parity flag.
  - STOP: each stop bit that votes 0 sets the frame flag. The frame completes at resolution of the final stop bit, not at its end.
    - If the frame flag is set and rx_s = 0, go to BREAK.
    - Otherwise go to IDLE.
  - BREAK: wait for rx_s = 1, then go to IDLE. A held-low line yields exactly one frame_err word.
- Output register, on frame completion:
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle, load rx_data and both flags and set rx_valid = 1.
  - Otherwise discard the new frame and pulse overrun_err for one cycle. The held word is unchanged.
- Accept: rx_valid & rx_ready with no completing frame clears rx_valid on the next edge. rx_data holds its last value after the accept.
- Reset: rst_n low at any time forces FSM = IDLE, counters = 0 and rx_s = 1. All outputs go to 0: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0. Any partial frame is dropped.

## Timing
- Start detection: 2 clk (synchroniser) plus 1 clk after the falling edge on rx.
- Frame delivery: rx_valid rises 1 clk after the final stop-bit resolution tick. That is about (1+DATA_BITS+P+STOP_BITS-0.5)·OVERSAMPLE·DIV + 3 clk after the start edge, where P = 1 if PARITY≠0, else 0.
- busy rises 1 clk after start detection. It falls in the same cycle rx_valid rises, or 1 clk after leaving BREAK.
- rx_ready may be held high permanently. A word is then visible for exactly 1 clk.
- No combinational path exists from rx_ready to any output.

## Test plan
Bench settings: CLOCK_FREQ = 1_600_000, BAUD_RATE = 100_000, OVERSAMPLE = 16 (DIV = 1, 16 clk per bit).
- 8N1, send 0xA5 with rx_ready = 0.
  - Expect rx_data = 0xA5, rx_valid = 1, all error flags 0, held until rx_ready = 1.
  - rx_valid = 0 one clk after the accept.
- PARITY = 2, send 0x3C once with parity bit 0, then with parity bit 1.
  - Expect parity_err = 0, then parity_err = 1. rx_data = 0x3C both times.
- Drive the stop bit of 0x81 low, then hold rx low for 30 bit times, then release and send 0x55.
  - Expect one word 0x81 with frame_err = 1, no further words during the low period, then 0x55 with no errors.
- Noise:
  - rx low for 4 clk from idle: no word, busy returns to 0.
  - A single-clk glitch at the centre of data bit 2 of 0x00: word 0x00 received.
- Overrun: send 0x11 then 0x22 with rx_ready = 0.
  - Expect rx_data = 0x11 retained and one overrun_err pulse at the completion of 0x22.
  - Assert rx_ready: rx_valid drops.
- Reset mid-frame: assert rst_n = 0 during data bit 3 of 0xF0.
  - All outputs 0, no word delivered.
  - A subsequent 0x0F is received correctly.
- Config sweep: DATA_BITS = 5, STOP_BITS = 2, send 0x1B.
  - rx_data = 0x1B.
  - A second stop bit driven 0 gives frame_err = 1.
